// File: rtl/ascon_tag_verify.sv
// Ascon decryption tag check: forms the expected tag from the finalized state and key,
// then compares a streamed received tag in constant time and reports pass/fail.
module ascon_tag_verify #(
    parameter int WORD_W = 32
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    input  logic              start_i,
    input  logic [4:0][63:0]  state_i,
    input  logic [127:0]      key_i,
    input  logic [WORD_W-1:0] tag_data_i,
    input  logic              tag_valid_i,
    output logic              tag_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              tag_ok_o
);
    localparam int N_WORDS = 128 / WORD_W;
    localparam int CNT_W   = $clog2(N_WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CMP
    } fsm_t;

    fsm_t              state;
    fsm_t              state_next;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] diff;
    logic [127:0]      exp_tag;
    logic              accept;
    logic              unused_state;

    // Only state words 3 and 4 carry the tag material.
    assign unused_state = ^state_i[2:0];
    assign accept       = (state == RECV) && tag_valid_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        tag_ready_o = 1'b0;
        busy_o      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_next = RECV;
            end
            RECV: begin
                tag_ready_o = 1'b1;
                busy_o      = 1'b1;
                if (tag_valid_i && (cnt == LAST_WORD)) state_next = CMP;
            end
            CMP: begin
                busy_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The expected tag is shifted left as words arrive, so its top word is always the
    // one to compare. Mismatches are OR-accumulated: no early exit, timing is data-blind.
    // NOTE: exp_tag is a plain register (not a memory), so resetting it is cheap and
    // keeps no stale key-derived material after reset.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cnt      <= '0;
            diff     <= '0;
            exp_tag  <= '0;
            done_o   <= 1'b0;
            tag_ok_o <= 1'b0;
        end else begin
            done_o <= (state == CMP);
            if ((state == IDLE) && start_i) begin
                exp_tag  <= {state_i[3] ^ key_i[127:64], state_i[4] ^ key_i[63:0]};
                cnt      <= '0;
                diff     <= '0;
                tag_ok_o <= 1'b0;
            end
            if (accept) begin
                diff    <= diff | (tag_data_i ^ exp_tag[127 -: WORD_W]);
                exp_tag <= exp_tag << WORD_W;
                cnt     <= cnt + CNT_W'(1);
            end
            if (state == CMP) begin
                tag_ok_o <= (diff == '0);
            end
        end
    end
endmodule

// File: tb/tb_ascon_tag_verify.sv
// Randomized self-checking bench for ascon_tag_verify against a transaction-level model
// that assembles the whole received tag and compares it with the expected tag at once.
module tb_ascon_tag_verify;
    localparam int W = 32;
    localparam int N = 128 / W;

    localparam logic [127:0] K1 = 128'h691AED630E81901F6CB10AD9CA912F80;
    localparam logic [63:0]  S3 = 64'h0C4C36A20853217C;
    localparam logic [63:0]  S4 = 64'h46487B3E06D9D7A8;
    localparam logic [127:0] T1 = 128'h6556DBC106D2B1632AF971E7CC48F828;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [4:0][63:0] state_in = '0;
    logic [127:0]     key = '0;
    logic [W-1:0]     tag_data = '0;
    logic             tag_valid = 1'b0;
    logic             tag_ready;
    logic             busy;
    logic             done;
    logic             tag_ok;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ascon_tag_verify #(.WORD_W(W)) dut (
        .clock_i    (clk),
        .resetb_i   (rst_n),
        .start_i    (start),
        .state_i    (state_in),
        .key_i      (key),
        .tag_data_i (tag_data),
        .tag_valid_i(tag_valid),
        .tag_ready_o(tag_ready),
        .busy_o     (busy),
        .done_o     (done),
        .tag_ok_o   (tag_ok)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: a run collects N words into m_rx, then one cycle later compares it whole.
    bit           m_active;
    int           m_words;
    logic [127:0] m_exp;
    logic [127:0] m_rx;
    bit           m_ok;
    int           m_done_cyc = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active   = 1'b0;
            m_words    = 0;
            m_ok       = 1'b0;
            m_done_cyc = -1;
            m_exp      = '0;
            m_rx       = '0;
        end else if (!m_active) begin
            if (start) begin
                m_exp    = {state_in[3] ^ key[127:64], state_in[4] ^ key[63:0]};
                m_rx     = '0;
                m_words  = 0;
                m_ok     = 1'b0;
                m_active = 1'b1;
            end
        end else if (m_words < N) begin
            if (tag_valid) begin
                m_rx[127 - m_words*W -: W] = tag_data;
                m_words++;
            end
        end else begin
            m_active   = 1'b0;
            m_ok       = (m_rx == m_exp);
            m_done_cyc = cyc + 1;
        end
    end

    always @(negedge clk) begin
        check("ready", 128'(tag_ready), 128'(m_active && (m_words < N)));
        check("busy",  128'(busy),      128'(m_active));
        check("done",  128'(done),      128'(cyc == m_done_cyc));
        check("ok",    128'(tag_ok),    128'(m_ok));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        for (int i = 0; i < 5; i++) state_in[i] = {$urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic start_run(input logic [63:0] s3, input logic [63:0] s4,
                             input logic [127:0] k, output int start_cyc);
        scramble();
        state_in[3] = s3;
        state_in[4] = s4;
        key         = k;
        start       = 1'b1;
        start_cyc   = cyc;
        tick();
        start = 1'b0;
        scramble();
    endtask

    // Gap cycles precede every word but the first; extra_start pulses start in each gap.
    task automatic send_tag(input logic [127:0] t, input int gap, input bit rand_gap,
                            input bit extra_start);
        for (int k = 0; k < N; k++) begin
            int g;
            g = (k == 0) ? 0 : (rand_gap ? int'($urandom_range(0, 3)) : gap);
            repeat (g) begin
                tag_valid = 1'b0;
                tag_data  = W'($urandom);
                start     = extra_start;
                if (extra_start) scramble();
                tick();
                start = 1'b0;
            end
            tag_valid = 1'b1;
            tag_data  = t[127 - k*W -: W];
            tick();
            tag_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output int done_cyc, output bit seen);
        seen     = 1'b0;
        done_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen     = 1'b1;
                done_cyc = cyc;
                return;
            end
        end
    endtask

    initial begin
        int  sc;
        int  dc;
        bit  seen;
        logic [127:0] t;
        logic [127:0] k;
        logic [63:0]  s3;
        logic [63:0]  s4;
        bit  flip;

        #2;
        check("rst_ready", 128'(tag_ready), 128'(0));
        check("rst_busy",  128'(busy),      128'(0));
        check("rst_done",  128'(done),      128'(0));
        check("rst_ok",    128'(tag_ok),    128'(0));
        #10 rst_n = 1'b1;
        tick();

        // 1: matching tag, back-to-back words
        start_run(S3, S4, K1, sc);
        check("t1_model_exp", m_exp, T1);
        send_tag(T1, 0, 1'b0, 1'b0);
        wait_done(dc, seen);
        check("t1_seen", 128'(seen), 128'(1));
        check("t1_latency", 128'(dc - sc), 128'(N + 2));
        check("t1_ok", 128'(tag_ok), 128'(1));
        tick();

        // 2: one flipped bit in the last word, same timing
        start_run(S3, S4, K1, sc);
        send_tag(T1 ^ 128'h1, 0, 1'b0, 1'b0);
        wait_done(dc, seen);
        check("t2_seen", 128'(seen), 128'(1));
        check("t2_latency", 128'(dc - sc), 128'(N + 2));
        check("t2_ok", 128'(tag_ok), 128'(0));
        tick();

        // 3: three idle cycles between words
        start_run(S3, S4, K1, sc);
        send_tag(T1, 3, 1'b0, 1'b0);
        wait_done(dc, seen);
        check("t3_seen", 128'(seen), 128'(1));
        check("t3_latency", 128'(dc - sc), 128'(N + 2 + 3 * (N - 1)));
        check("t3_ok", 128'(tag_ok), 128'(1));
        tick();

        // 4: start pulses with other state during RECV are ignored
        start_run(S3, S4, K1, sc);
        send_tag(T1, 1, 1'b0, 1'b1);
        wait_done(dc, seen);
        check("t4_seen", 128'(seen), 128'(1));
        check("t4_ok", 128'(tag_ok), 128'(1));
        tick();

        // 5: asynchronous reset after two words
        start_run(S3, S4, K1, sc);
        for (int i = 0; i < 2; i++) begin
            tag_valid = 1'b1;
            tag_data  = T1[127 - i*W -: W];
            tick();
        end
        tag_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_ready", 128'(tag_ready), 128'(0));
        check("t5_busy",  128'(busy),      128'(0));
        check("t5_done",  128'(done),      128'(0));
        check("t5_ok",    128'(tag_ok),    128'(0));
        #4 rst_n = 1'b1;
        tick();
        start_run(S3, S4, K1, sc);
        send_tag(T1, 0, 1'b0, 1'b0);
        wait_done(dc, seen);
        check("t5_rerun_seen", 128'(seen), 128'(1));
        check("t5_rerun_ok", 128'(tag_ok), 128'(1));
        tick();

        // 6: restart in the done cycle, then a mismatching tag
        start_run(S3, S4, K1, sc);
        send_tag(T1, 0, 1'b0, 1'b0);
        tick();
        check("t6_done_cycle", 128'(done), 128'(1));
        check("t6_ok_before", 128'(tag_ok), 128'(1));
        start_run(S3, S4, K1, sc);
        check("t6_ok_cleared", 128'(tag_ok), 128'(0));
        send_tag(T1 ^ {32'h0001_0000, 96'h0}, 0, 1'b0, 1'b0);
        wait_done(dc, seen);
        check("t6_seen", 128'(seen), 128'(1));
        check("t6_latency", 128'(dc - sc), 128'(N + 2));
        check("t6_ok", 128'(tag_ok), 128'(0));
        tick();

        // Randomized runs: random key/state, gaps, stray valids and starts, bit flips
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 2)) begin
                tag_valid = 1'b1;
                tag_data  = W'($urandom);
                tick();
            end
            tag_valid = 1'b0;
            k  = {$urandom, $urandom, $urandom, $urandom};
            s3 = {$urandom, $urandom};
            s4 = {$urandom, $urandom};
            t  = {s3 ^ k[127:64], s4 ^ k[63:0]};
            flip = 1'($urandom_range(0, 1));
            if (flip) t = t ^ (128'h1 << $urandom_range(0, 127));
            start_run(s3, s4, k, sc);
            send_tag(t, 0, 1'b1, 1'($urandom_range(0, 1)));
            wait_done(dc, seen);
            check("rnd_seen", 128'(seen), 128'(1));
            check("rnd_ok", 128'(tag_ok), 128'(!flip));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
